// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: round-robin arbitration of NREQ command sources
// into a FIFO, issued one at a time on the command bus with timeout.
module cmd_dispatcher #(
    parameter int CSIZE  = 4,
    parameter int LSIZE  = 24,
    parameter int SLIZE  = 16,
    parameter int NREQ   = 4,
    parameter int QDEPTH = 4,
    parameter int TOW    = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*CSIZE-1:0]     req_cmd,
    input  logic [NREQ*LSIZE-1:0]     req_len,
    output logic [NREQ-1:0]           req_done,
    output logic [NREQ-1:0]           req_err,
    output logic                      request,
    output logic [LSIZE-1:0]          bus_len,
    output logic [CSIZE-1:0]          bus_cmd,
    input  logic [SLIZE-1:0]          busy,
    input  logic [SLIZE-1:0]          finish,
    input  logic [TOW-1:0]            timeout_limit,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      err_timeout
);

    localparam int RW = $clog2(NREQ);
    localparam int QW = $clog2(QDEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [RW-1:0]    fifo_src_q [QDEPTH];
    logic [CSIZE-1:0] fifo_cmd_q [QDEPTH];
    logic [LSIZE-1:0] fifo_len_q [QDEPTH];

    logic [QW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QW:0]      count_q, count_d;
    logic [RW-1:0]    rr_q, rr_d;
    logic [2:0]       state_q, state_d;
    logic [RW-1:0]    src_q, src_d;
    logic [CSIZE-1:0] cmd_q, cmd_d;
    logic [LSIZE-1:0] len_q, len_d;
    logic [TOW-1:0]   tmo_q, tmo_d;
    logic             err_tmo_q, err_tmo_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             gnt_found;
    logic [RW-1:0]    gnt_idx;
    logic [RW-1:0]    gnt_next;
    logic [NREQ-1:0]  rot;
    logic [RW-1:0]    off;
    logic [RW:0]      sum;
    logic [RW:0]      nsum;
    logic [SLIZE-1:0] slot_sel;
    logic             slot_busy;
    logic             slot_fin;
    logic             tmo_hit;
    logic [CSIZE-1:0] head_cmd;
    logic             head_bad;

    assign full = (count_q == (QW+1)'(QDEPTH));
    assign push = gnt_found && !full;
    assign pop  = (state_q == ST_IDLE) && (count_q != '0);

    assign head_cmd = fifo_cmd_q[rd_ptr_q];
    assign head_bad = ({1'b0, head_cmd} >= (CSIZE+1)'(SLIZE));

    // Round-robin search: rotate so rr_q sits at bit 0, take first set bit.
    always_comb begin
        rot       = NREQ'({req_valid, req_valid} >> rr_q);
        off       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && rot[k]) begin
                gnt_found = 1'b1;
                off       = RW'(k);
            end
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= (RW+1)'(NREQ)) begin
            sum = sum - (RW+1)'(NREQ);
        end
        gnt_idx = sum[RW-1:0];
        nsum    = sum + (RW+1)'(1);
        if (nsum >= (RW+1)'(NREQ)) begin
            nsum = nsum - (RW+1)'(NREQ);
        end
        gnt_next = nsum[RW-1:0];
    end

    // One-hot ready for the granted requester, only when a push happens.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = push && (gnt_idx == RW'(j));
        end
    end

    // Queue pointers, occupancy and round-robin pointer update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + QW'(1);
            rr_d     = gnt_next;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + QW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (QW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (QW+1)'(1);
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_src_q[wr_ptr_q] <= gnt_idx;
            fifo_cmd_q[wr_ptr_q] <= req_cmd[gnt_idx*CSIZE +: CSIZE];
            fifo_len_q[wr_ptr_q] <= req_len[gnt_idx*LSIZE +: LSIZE];
        end
    end

    // Decode the latched cmd into a slot mask for busy/finish selection.
    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < SLIZE; i++) begin
            slot_sel[i] = (cmd_q == CSIZE'(i));
        end
    end

    assign slot_busy = |(busy & slot_sel);
    assign slot_fin  = |(finish & slot_sel);
    assign tmo_hit   = (timeout_limit != '0) && (tmo_q == timeout_limit);

    // Executor FSM; finish beats timeout, timeout beats busy.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        err_tmo_d = err_tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    src_d   = fifo_src_q[rd_ptr_q];
                    cmd_d   = head_cmd;
                    len_d   = fifo_len_q[rd_ptr_q];
                    tmo_d   = '0;
                    state_d = head_bad ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d = tmo_q + TOW'(1);
                if (slot_fin) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d   = ST_ERR;
                    err_tmo_d = 1'b1;
                end else if (slot_busy) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                tmo_d = tmo_q + TOW'(1);
                if (slot_fin) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d   = ST_ERR;
                    err_tmo_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_q      <= '0;
            state_q   <= ST_IDLE;
            src_q     <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            state_q   <= state_d;
            src_q     <= src_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    // Completion pulses routed back to the originating requester.
    always_comb begin
        req_done = '0;
        req_err  = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_done[j] = ((state_q == ST_DONE) || (state_q == ST_ERR))
                          && (src_q == RW'(j));
            req_err[j]  = (state_q == ST_ERR) && (src_q == RW'(j));
        end
    end

    assign request     = (state_q == ST_ISSUE);
    assign bus_cmd     = cmd_q;
    assign bus_len     = len_q;
    assign q_count     = count_q;
    assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed vector table plus hand-written
// sequences for timeout, finish race, bad cmd and mid-command reset.
module tb_cmd_dispatcher;

    logic        clock;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_cmd;
    logic [95:0] req_len;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic        request;
    logic [23:0] bus_len;
    logic [3:0]  bus_cmd;
    logic [11:0] busy;
    logic [11:0] finish;
    logic [15:0] timeout_limit;
    logic [2:0]  q_count;
    logic        err_timeout;

    int n_chk;
    int n_fail;

    cmd_dispatcher #(
        .CSIZE(4), .LSIZE(24), .SLIZE(12),
        .NREQ(4), .QDEPTH(4), .TOW(16)
    ) dut (
        .clock(clock),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_len(req_len),
        .req_done(req_done),
        .req_err(req_err),
        .request(request),
        .bus_len(bus_len),
        .bus_cmd(bus_cmd),
        .busy(busy),
        .finish(finish),
        .timeout_limit(timeout_limit),
        .q_count(q_count),
        .err_timeout(err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [11:0] b;
        logic [11:0] f;
        logic [3:0]  rdy;
        logic        req;
        logic [3:0]  done;
        logic [3:0]  err;
        logic [2:0]  q;
        logic [3:0]  cmd;
        logic [23:0] len;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] v,
                       input logic [11:0] b, input logic [11:0] f,
                       input logic [3:0] rdy, input logic req,
                       input logic [3:0] done, input logic [3:0] err,
                       input logic [2:0] q, input logic [3:0] cmd,
                       input logic [23:0] len);
        vec_t e;
        e.r = r; e.v = v; e.b = b; e.f = f;
        e.rdy = rdy; e.req = req; e.done = done; e.err = err;
        e.q = q; e.cmd = cmd; e.len = len;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        busy = '0;
        finish = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        vec_t e;
        logic ok;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        busy = '0;
        finish = '0;
        timeout_limit = '0;
        req_cmd = {4'd7, 4'd6, 4'd3, 4'd4};
        req_len = {24'hFFFFFF, 24'hABCDEF, 24'h000100, 24'h000055};

        // Single command from requester 1: cmd 3, len 0x100.
        add(1, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(1, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'h2, 12'h0,   12'h0,   4'h2, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd1, 4'd0, 24'h0);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 1, 4'h0, 4'h0, 3'd0, 4'd3, 24'h100);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 1, 4'h0, 4'h0, 3'd0, 4'd3, 24'h100);
        add(0, 4'h0, 12'h008, 12'h0,   4'h0, 1, 4'h0, 4'h0, 3'd0, 4'd3, 24'h100);
        for (int i = 0; i < 9; i++)
            add(0, 4'h0, 12'h0, 12'h0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'h0, 12'h0,   12'h008, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h2, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        // Round-robin with all requesters valid, fill and full boundary.
        add(1, 4'h0, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'hF, 12'h0,   12'h0,   4'h1, 0, 4'h0, 4'h0, 3'd0, 4'd0, 24'h0);
        add(0, 4'hF, 12'h0,   12'h0,   4'h2, 0, 4'h0, 4'h0, 3'd1, 4'd0, 24'h0);
        add(0, 4'hF, 12'h0,   12'h0,   4'h4, 1, 4'h0, 4'h0, 3'd1, 4'd4, 24'h55);
        add(0, 4'hF, 12'h0,   12'h0,   4'h8, 1, 4'h0, 4'h0, 3'd2, 4'd4, 24'h55);
        add(0, 4'hF, 12'h0,   12'h0,   4'h1, 1, 4'h0, 4'h0, 3'd3, 4'd4, 24'h55);
        add(0, 4'hF, 12'h0,   12'h010, 4'h0, 1, 4'h0, 4'h0, 3'd4, 4'd4, 24'h55);
        add(0, 4'hF, 12'h0,   12'h0,   4'h0, 0, 4'h1, 4'h0, 3'd4, 4'd0, 24'h0);
        add(0, 4'hF, 12'h0,   12'h0,   4'h0, 0, 4'h0, 4'h0, 3'd4, 4'd0, 24'h0);
        add(0, 4'hF, 12'h0,   12'h0,   4'h2, 1, 4'h0, 4'h0, 3'd3, 4'd3, 24'h100);
        add(0, 4'h0, 12'h0,   12'h0,   4'h0, 1, 4'h0, 4'h0, 3'd4, 4'd3, 24'h100);

        cyc();
        foreach (tbl[i]) begin
            e = tbl[i];
            rst = e.r;
            req_valid = e.v;
            busy = e.b;
            finish = e.f;
            #1;
            if (!e.r) begin
                chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(e.rdy));
                chk($sformatf("row%0d_req", i), 32'(request), 32'(e.req));
                chk($sformatf("row%0d_done", i), 32'(req_done), 32'(e.done));
                chk($sformatf("row%0d_err", i), 32'(req_err), 32'(e.err));
                chk($sformatf("row%0d_q", i), 32'(q_count), 32'(e.q));
                if (e.req) begin
                    chk($sformatf("row%0d_cmd", i), 32'(bus_cmd), 32'(e.cmd));
                    chk($sformatf("row%0d_len", i), 32'(bus_len), 32'(e.len));
                end
            end
            cyc();
        end

        // Timeout: requester 2 never sees busy/finish, requester 3 queued.
        do_reset();
        chk("rst_errt", 32'(err_timeout), 32'd0);
        chk("rst_cmd", 32'(bus_cmd), 32'd0);
        timeout_limit = 16'd20;
        req_valid = 4'b0100;
        cyc();
        req_valid = 4'b1000;
        #1;
        chk("tmo_rdy3", 32'(req_ready), 32'h8);
        cyc();
        req_valid = 4'b0000;
        chk("tmo_req", 32'(request), 32'd1);
        chk("tmo_cmd", 32'(bus_cmd), 32'd6);
        chk("tmo_q", 32'(q_count), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (request !== 1'b1 || req_done !== 4'h0) ok = 1'b0;
        end
        chk("tmo_hold", 32'(ok), 32'd1);
        cyc();
        chk("tmo_done", 32'(req_done), 32'h4);
        chk("tmo_err", 32'(req_err), 32'h4);
        chk("tmo_flag", 32'(err_timeout), 32'd1);
        chk("tmo_reqlo", 32'(request), 32'd0);
        cyc();
        chk("tmo_done0", 32'(req_done), 32'h0);
        chk("tmo_flag2", 32'(err_timeout), 32'd1);
        cyc();
        chk("tmo_next_req", 32'(request), 32'd1);
        chk("tmo_next_cmd", 32'(bus_cmd), 32'd7);
        chk("tmo_next_len", 32'(bus_len), 32'hFFFFFF);
        finish = 12'h080;
        cyc();
        finish = '0;
        chk("imm_done", 32'(req_done), 32'h8);
        chk("imm_err", 32'(req_err), 32'h0);
        chk("imm_flag", 32'(err_timeout), 32'd1);
        cyc();
        chk("imm_done0", 32'(req_done), 32'h0);

        // Finish coincident with timeout: finish wins.
        do_reset();
        timeout_limit = 16'd5;
        req_valid = 4'b0010;
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("race_req", 32'(request), 32'd1);
        busy = 12'h008;
        cyc();
        busy = 12'h010;
        finish = 12'h010;
        chk("race_exec", 32'(request), 32'd0);
        cyc();
        busy = '0;
        finish = '0;
        chk("race_other", 32'(req_done), 32'h0);
        cyc();
        cyc();
        cyc();
        finish = 12'h008;
        cyc();
        finish = '0;
        chk("race_done", 32'(req_done), 32'h2);
        chk("race_err", 32'(req_err), 32'h0);
        chk("race_flag", 32'(err_timeout), 32'd0);

        // Out-of-range cmd 13 with 12 slots.
        do_reset();
        timeout_limit = '0;
        req_cmd[3:0] = 4'd13;
        req_valid = 4'b0001;
        #1;
        chk("oor_rdy", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        ok = (request === 1'b0);
        cyc();
        ok = ok && (request === 1'b0);
        chk("oor_done", 32'(req_done), 32'h1);
        chk("oor_err", 32'(req_err), 32'h1);
        chk("oor_flag", 32'(err_timeout), 32'd0);
        cyc();
        ok = ok && (request === 1'b0);
        chk("oor_noreq", 32'(ok), 32'd1);
        chk("oor_done0", 32'(req_done), 32'h0);
        req_cmd[3:0] = 4'd4;

        // Reset while a command is in EXEC with one more queued.
        req_valid = 4'b0100;
        #1;
        chk("mid_rdy2", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b1000;
        cyc();
        req_valid = 4'b0000;
        chk("mid_req", 32'(request), 32'd1);
        busy = 12'h040;
        cyc();
        busy = '0;
        chk("mid_exec", 32'(request), 32'd0);
        chk("mid_q", 32'(q_count), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        finish = 12'h040;
        chk("mid_rst_req", 32'(request), 32'd0);
        chk("mid_rst_q", 32'(q_count), 32'd0);
        chk("mid_rst_done", 32'(req_done), 32'h0);
        chk("mid_rst_cmd", 32'(bus_cmd), 32'd0);
        chk("mid_rst_len", 32'(bus_len), 32'd0);
        cyc();
        finish = '0;
        chk("mid_nodone", 32'(req_done), 32'h0);
        chk("mid_noreq", 32'(request), 32'd0);
        cyc();
        chk("mid_nodone2", 32'(req_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
